// File: rtl/gate_game_pkg.sv
// gate_game_pkg: shared state encoding, clog2 helper and LFSR defaults for the gate challenge.
package gate_game_pkg;
    typedef enum logic [2:0] {IDLE, PICK, PLAY, PENALTY, DONE} state_t;
    localparam logic [15:0] DEFAULT_SEED = 16'hACE1;
    localparam logic [15:0] DEFAULT_TAPS = 16'hB400;
    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction
endpackage

// File: rtl/button_edge.sv
// button_edge: 2-flop synchroniser plus falling-edge detector; one pulse per press of an active-low key.
module button_edge (
    input  logic clk,
    input  logic resetn,
    input  logic key,
    output logic press
);
    logic s1, s2, s3;
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) {s1, s2, s3} <= 3'b111;
        else         {s1, s2, s3} <= {key, s1, s2};
    end
    assign press = s3 & ~s2;
endmodule

// File: rtl/gate_challenge_ctrl.sv
// gate_challenge_ctrl: round controller for the logic-gate game -- cursor, non-repeating random
// target pick, completion mask, elapsed timer and timed wrong-answer blankout.
module gate_challenge_ctrl
    import gate_game_pkg::*;
#(
    parameter int                NUM_GATES      = 9,
    parameter int                LFSR_W         = 16,
    parameter logic [LFSR_W-1:0] LFSR_SEED      = LFSR_W'(DEFAULT_SEED),
    parameter logic [LFSR_W-1:0] LFSR_TAPS      = LFSR_W'(DEFAULT_TAPS),
    parameter int                PENALTY_CYCLES = 50000000,
    parameter int                TIMER_W        = 32
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 switch_key,
    input  logic                 confirm_key,
    output logic [NUM_GATES-1:0] selected_gate,
    output logic [NUM_GATES-1:0] target_gate,
    output logic [NUM_GATES-1:0] completed_gate,
    output logic                 timer_en,
    output logic [TIMER_W-1:0]   elapsed,
    output logic                 vga_blankout,
    output logic                 game_done,
    output logic [7:0]           error_count
);
    localparam int IDX_W = clog2(NUM_GATES);
    localparam int PEN_W = (clog2(PENALTY_CYCLES) > 0) ? clog2(PENALTY_CYCLES) : 1;
    localparam logic [IDX_W:0] NG = (IDX_W + 1)'(NUM_GATES);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_GATES - 1);
    localparam logic [PEN_W-1:0] PEN_LOAD = PEN_W'(PENALTY_CYCLES - 1);

    state_t state, state_nxt;
    logic sw_p, cf_p;
    logic [LFSR_W-1:0] lfsr;
    logic [IDX_W-1:0] idx, idx_nxt, cur_idx, lfsr_idx;
    logic [IDX_W:0] raw_idx;
    logic first, first_nxt;
    logic [PEN_W-1:0] pen, pen_nxt;
    logic [NUM_GATES-1:0] sel_nxt, tgt_nxt, comp_nxt, pick_oh, hit_mask;
    logic timer_en_nxt, blank_nxt, done_nxt;
    logic [TIMER_W-1:0] elapsed_nxt;
    logic [7:0] err_nxt;

    button_edge u_switch (.clk(clk), .resetn(resetn), .key(switch_key), .press(sw_p));
    button_edge u_confirm (.clk(clk), .resetn(resetn), .key(confirm_key), .press(cf_p));

    // Fold the raw LFSR slice into range once; the probe then walks linearly so it ends within NUM_GATES cycles.
    assign raw_idx  = {1'b0, lfsr[IDX_W-1:0]};
    assign lfsr_idx = IDX_W'((raw_idx >= NG) ? raw_idx - NG : raw_idx);
    assign cur_idx  = first ? lfsr_idx : idx;
    assign pick_oh  = NUM_GATES'(1) << cur_idx;
    assign hit_mask = completed_gate | target_gate;

    always_comb begin
        state_nxt    = state;
        idx_nxt      = idx;
        first_nxt    = first;
        pen_nxt      = pen;
        sel_nxt      = selected_gate;
        tgt_nxt      = target_gate;
        comp_nxt     = completed_gate;
        timer_en_nxt = timer_en;
        blank_nxt    = vga_blankout;
        done_nxt     = game_done;
        err_nxt      = error_count;
        elapsed_nxt  = (timer_en && !(&elapsed)) ? elapsed + 1'b1 : elapsed;
        if (sw_p && (state == IDLE || state == PICK || state == PLAY))
            sel_nxt = {selected_gate[NUM_GATES-2:0], selected_gate[NUM_GATES-1]};
        case (state)
            IDLE: if (cf_p) begin
                state_nxt    = PICK;
                first_nxt    = 1'b1;
                timer_en_nxt = 1'b1;
                elapsed_nxt  = '0;
                err_nxt      = '0;
                comp_nxt     = '0;
            end
            PICK: begin
                first_nxt = 1'b0;
                if ((completed_gate & pick_oh) == '0) begin
                    tgt_nxt   = pick_oh;
                    state_nxt = PLAY;
                end else begin
                    idx_nxt = (cur_idx == LAST_IDX) ? '0 : cur_idx + 1'b1;
                end
            end
            PLAY: if (cf_p) begin
                if (selected_gate == target_gate) begin
                    comp_nxt = hit_mask;
                    tgt_nxt  = '0;
                    if (&hit_mask) begin
                        state_nxt    = DONE;
                        timer_en_nxt = 1'b0;
                        done_nxt     = 1'b1;
                    end else begin
                        state_nxt = PICK;
                        first_nxt = 1'b1;
                    end
                end else begin
                    err_nxt   = (error_count == 8'hFF) ? error_count : error_count + 8'd1;
                    blank_nxt = 1'b1;
                    pen_nxt   = PEN_LOAD;
                    state_nxt = PENALTY;
                end
            end
            PENALTY: begin
                pen_nxt = (pen == '0) ? pen : pen - 1'b1;
                if (pen == '0) begin
                    blank_nxt = 1'b0;
                    state_nxt = PLAY;
                end
            end
            DONE: if (cf_p) begin
                state_nxt = IDLE;
                done_nxt  = 1'b0;
                comp_nxt  = '0;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state          <= IDLE;
            lfsr           <= LFSR_SEED;
            idx            <= '0;
            first          <= 1'b0;
            pen            <= '0;
            selected_gate  <= NUM_GATES'(1);
            target_gate    <= '0;
            completed_gate <= '0;
            timer_en       <= 1'b0;
            elapsed        <= '0;
            vga_blankout   <= 1'b0;
            game_done      <= 1'b0;
            error_count    <= '0;
        end else begin
            state          <= state_nxt;
            lfsr           <= lfsr[0] ? (lfsr >> 1) ^ LFSR_TAPS : lfsr >> 1;
            idx            <= idx_nxt;
            first          <= first_nxt;
            pen            <= pen_nxt;
            selected_gate  <= sel_nxt;
            target_gate    <= tgt_nxt;
            completed_gate <= comp_nxt;
            timer_en       <= timer_en_nxt;
            elapsed        <= elapsed_nxt;
            vga_blankout   <= blank_nxt;
            game_done      <= done_nxt;
            error_count    <= err_nxt;
        end
    end
endmodule

// File: tb/tb_gate_challenge_ctrl.sv
// tb_gate_challenge_ctrl: directed self-checking bench for gate_challenge_ctrl with 4 gates,
// a 3-cycle penalty and an 8-bit timer.
module tb_gate_challenge_ctrl;
    logic       clk = 1'b0;
    logic       resetn, switch_key, confirm_key;
    logic [3:0] selected_gate, target_gate, completed_gate;
    logic       timer_en, vga_blankout, game_done;
    logic [7:0] elapsed, error_count;
    int         checks = 0, failures = 0;
    logic [3:0] cur, t, mask;
    logic [7:0] e_hold;
    int         n, m, cnt;

    gate_challenge_ctrl #(.NUM_GATES(4), .PENALTY_CYCLES(3), .TIMER_W(8)) dut (
        .clk(clk), .resetn(resetn), .switch_key(switch_key), .confirm_key(confirm_key),
        .selected_gate(selected_gate), .target_gate(target_gate), .completed_gate(completed_gate),
        .timer_en(timer_en), .elapsed(elapsed), .vga_blankout(vga_blankout),
        .game_done(game_done), .error_count(error_count)
    );

    always #5 clk = ~clk;

    function automatic logic [3:0] rot(input logic [3:0] v);
        return {v[2:0], v[3]};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int k = 1);
        repeat (k) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_sel"}, 32'(selected_gate), 32'h1);
        chk({tag, "_tgt"}, 32'(target_gate), 32'h0);
        chk({tag, "_comp"}, 32'(completed_gate), 32'h0);
        chk({tag, "_ten"}, 32'(timer_en), 32'h0);
        chk({tag, "_elapsed"}, 32'(elapsed), 32'h0);
        chk({tag, "_blank"}, 32'(vga_blankout), 32'h0);
        chk({tag, "_done"}, 32'(game_done), 32'h0);
        chk({tag, "_err"}, 32'(error_count), 32'h0);
    endtask

    task automatic press_sw();
        switch_key = 1'b0;
        tick(4);
        switch_key = 1'b1;
        tick(4);
        cur = rot(cur);
    endtask

    task automatic press_cf();
        confirm_key = 1'b0;
        tick(4);
        confirm_key = 1'b1;
        tick(4);
    endtask

    task automatic wait_tgt(input string tag);
        int k;
        k = 0;
        while (target_gate == 4'h0 && k < 10) begin
            tick();
            k++;
        end
        chk({tag, "_onehot"}, 32'($onehot(target_gate)), 32'h1);
        chk({tag, "_fresh"}, 32'((target_gate & mask) == 4'h0), 32'h1);
    endtask

    task automatic seek(input logic [3:0] tg);
        for (int i = 0; i < 4 && cur != tg; i++) press_sw();
        chk("seek_cursor", 32'(selected_gate), 32'(tg));
    endtask

    task automatic wrong_confirm();
        if (cur == t) press_sw();
        confirm_key = 1'b0;
        n = 0;
        while (!vga_blankout && n < 8) begin
            tick();
            n++;
        end
    endtask

    initial begin
        resetn = 1'b0;
        switch_key = 1'b1;
        confirm_key = 1'b1;
        mask = 4'h0;
        cur = 4'b0001;
        tick(2);
        chk_reset("reset");
        resetn = 1'b1;
        tick(2);

        for (int i = 0; i < 5; i++) begin
            press_sw();
            chk("cursor_step", 32'(selected_gate), 32'(cur));
        end
        switch_key = 1'b0;
        tick(20);
        switch_key = 1'b1;
        tick(4);
        cur = rot(cur);
        chk("cursor_held", 32'(selected_gate), 32'(cur));

        confirm_key = 1'b0;
        n = 0;
        while (!timer_en && n < 8) begin
            tick();
            n++;
        end
        chk("start_ten", 32'(timer_en), 32'h1);
        chk("start_elapsed", 32'(elapsed), 32'h0);
        m = 0;
        while (target_gate == 4'h0 && m < 8) begin
            tick();
            m++;
        end
        chk("pick_latency", 32'(m >= 1 && m <= 4), 32'h1);
        chk("elapsed_count", 32'(elapsed), 32'(m));
        confirm_key = 1'b1;
        tick(4);

        for (int r = 0; r < 4; r++) begin
            wait_tgt("round_tgt");
            t = target_gate;
            if (r == 0) begin
                wrong_confirm();
                confirm_key = 1'b1;
                switch_key = 1'b0;
                cnt = vga_blankout ? 1 : 0;
                for (int i = 0; i < 10; i++) begin
                    tick();
                    cnt += vga_blankout ? 1 : 0;
                end
                switch_key = 1'b1;
                chk("penalty_len", 32'(cnt), 32'd3);
                chk("penalty_err", 32'(error_count), 32'd1);
                chk("penalty_cursor", 32'(selected_gate), 32'(cur));
                chk("penalty_same_tgt", 32'(target_gate), 32'(t));
                tick(4);
            end
            seek(t);
            mask = mask | t;
            if (r == 3) begin
                switch_key = 1'b0;
                confirm_key = 1'b0;
                tick(4);
                switch_key = 1'b1;
                confirm_key = 1'b1;
                tick(4);
                cur = rot(cur);
                chk("simul_cursor", 32'(selected_gate), 32'(cur));
            end else begin
                press_cf();
            end
            chk("round_completed", 32'(completed_gate), 32'(mask));
        end

        chk("done_flag", 32'(game_done), 32'h1);
        chk("done_ten", 32'(timer_en), 32'h0);
        chk("done_tgt", 32'(target_gate), 32'h0);
        e_hold = elapsed;
        tick(5);
        chk("done_elapsed_frozen", 32'(elapsed), 32'(e_hold));
        chk("done_cursor_hold", 32'(selected_gate), 32'(cur));

        press_cf();
        chk("restart_done", 32'(game_done), 32'h0);
        chk("restart_comp", 32'(completed_gate), 32'h0);
        chk("restart_ten", 32'(timer_en), 32'h0);
        chk("restart_elapsed_kept", 32'(elapsed), 32'(e_hold));
        chk("restart_err_kept", 32'(error_count), 32'd1);

        mask = 4'h0;
        press_cf();
        chk("game2_ten", 32'(timer_en), 32'h1);
        chk("game2_err_clear", 32'(error_count), 32'd0);
        tick(300);
        chk("elapsed_saturate", 32'(elapsed), 32'd255);
        wait_tgt("game2_tgt");
        t = target_gate;
        seek(t);
        mask = t;
        press_cf();
        wait_tgt("game2_tgt2");
        t = target_gate;
        wrong_confirm();
        chk("midpen_blank", 32'(vga_blankout), 32'h1);
        chk("midpen_comp", 32'(completed_gate), 32'(mask));
        #2;
        resetn = 1'b0;
        #1;
        chk_reset("async_reset");
        confirm_key = 1'b1;
        tick(2);
        resetn = 1'b1;
        tick(2);
        chk_reset("post_reset");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
